// File: rtl/instr_decode_unit_if.sv
// Bus between control_unit and instr_decode_unit: fetched word, load/decode strobes and decoded fields.
// ILLEGAL_OPCODE_DETECT_EN adds the sticky illegal_op flag to the bus.
interface instr_decode_unit_if #(
    parameter int INSTR_W = 16,
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 16
);
    logic [INSTR_W-1:0] instr_in;
    logic               inst_wr;
    logic               decoder_en;
    logic [3:0]         opcode;
    logic [3:0]         rd_sel;
    logic [3:0]         ra_sel;
    logic [3:0]         rb_sel;
    logic [DATA_W-1:0]  imm_out;
    logic               decode_valid;
    logic [CNT_W-1:0]   instr_count;
`ifdef ILLEGAL_OPCODE_DETECT_EN
    logic               illegal_op;

    modport master (
        output instr_in, inst_wr, decoder_en,
        input  opcode, rd_sel, ra_sel, rb_sel, imm_out, decode_valid, instr_count, illegal_op
    );
    modport slave (
        input  instr_in, inst_wr, decoder_en,
        output opcode, rd_sel, ra_sel, rb_sel, imm_out, decode_valid, instr_count, illegal_op
    );
`else
    modport master (
        output instr_in, inst_wr, decoder_en,
        input  opcode, rd_sel, ra_sel, rb_sel, imm_out, decode_valid, instr_count
    );
    modport slave (
        input  instr_in, inst_wr, decoder_en,
        output opcode, rd_sel, ra_sel, rb_sel, imm_out, decode_valid, instr_count
    );
`endif
endinterface

// File: rtl/instr_decode_unit.sv
// Instruction register and field decoder feeding control_unit, register file and ALU.
// Optional ILLEGAL_OPCODE_DETECT_EN: sticky flag for opcodes 8-F seen at decode.
module instr_decode_unit #(
    parameter int INSTR_W = 16,
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    instr_decode_unit_if.slave    bus
);
    logic [INSTR_W-1:0] ir;
    logic [3:0]         rd_q;
    logic [3:0]         ra_q;
    logic [3:0]         rb_q;
    logic [DATA_W-1:0]  imm_q;
    logic               valid_q;
    logic [CNT_W-1:0]   count_q;

    // Decode reads the pre-edge ir, so a same-edge load never leaks into the fields.
    always_ff @(posedge clock) begin
        if (reset) begin
            ir      <= '0;
            rd_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            imm_q   <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            valid_q <= bus.decoder_en;
            if (bus.inst_wr) begin
                ir <= bus.instr_in;
            end
            if (bus.decoder_en) begin
                rd_q    <= ir[11:8];
                ra_q    <= ir[7:4];
                rb_q    <= ir[3:0];
                imm_q   <= DATA_W'(ir[7:0]);
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign bus.opcode       = ir[INSTR_W-1 -: 4];
    assign bus.rd_sel       = rd_q;
    assign bus.ra_sel       = ra_q;
    assign bus.rb_sel       = rb_q;
    assign bus.imm_out      = imm_q;
    assign bus.decode_valid = valid_q;
    assign bus.instr_count  = count_q;

`ifdef ILLEGAL_OPCODE_DETECT_EN
    logic illegal_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (bus.decoder_en && ir[INSTR_W-1]) begin
            illegal_q <= 1'b1;
        end
    end

    assign bus.illegal_op = illegal_q;
`endif

endmodule
